// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the reset sequencer and the rest of the system.
// The sequencer uses the slave modport; the requester/observer side uses master.
interface rst_sequencer_if;
    logic       sw_rst_req_i;
    logic       ddr_calib_i;
    logic       net_resetdone_i;
    logic       ddr_rst_o;
    logic       net_rst_o;
    logic       soc_rst_n_o;
    logic       done_o;
    logic       fault_o;
    logic [2:0] state_o;

    modport slave (
        input  sw_rst_req_i, ddr_calib_i, net_resetdone_i,
        output ddr_rst_o, net_rst_o, soc_rst_n_o, done_o, fault_o, state_o
    );

    modport master (
        output sw_rst_req_i, ddr_calib_i, net_resetdone_i,
        input  ddr_rst_o, net_rst_o, soc_rst_n_o, done_o, fault_o, state_o
    );
endinterface

// File: rtl/rst_sequencer.sv
// Board reset sequencer: HOLD -> DDR calib -> NET resetdone -> SoC settle -> RUN.
// Optional macro RST_SEQ_RETRY_EN retries timed-out waits up to MAX_RETRIES times before FAULT.
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 2**20,
    parameter int unsigned SOC_SETTLE     = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    rst_sequencer_if.slave   bus
);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SOC_W  = $clog2(SOC_SETTLE + 1);

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_DDR   = 3'd1,
        ST_NET   = 3'd2,
        ST_SOC   = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [SOC_W-1:0]    soc_cnt_q, soc_cnt_d;
    logic [1:0]          calib_sync_q, rdone_sync_q;
    logic                ddr_rst_q, net_rst_q, soc_rst_n_q, done_q, fault_q;
    logic                calib_s, rdone_s, timeout_c, to_hit_c, entry_c;

`ifdef RST_SEQ_RETRY_EN
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);
    logic [RTY_W-1:0]    retry_q, retry_d;
`else
    // Retry limit is meaningless when every timeout is fatal.
    logic unused_retry_c;
    assign unused_retry_c = ^32'(MAX_RETRIES);
`endif

    assign calib_s   = calib_sync_q[1];
    assign rdone_s   = rdone_sync_q[1];
    assign timeout_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            calib_sync_q <= 2'b00;
            rdone_sync_q <= 2'b00;
        end else begin
            calib_sync_q <= {calib_sync_q[0], bus.ddr_calib_i};
            rdone_sync_q <= {rdone_sync_q[0], bus.net_resetdone_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;
        soc_cnt_d  = soc_cnt_q;
        to_hit_c   = 1'b0;
`ifdef RST_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            ST_HOLD:  if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = ST_DDR;
            ST_DDR:   if (calib_s) state_d = ST_NET; else if (timeout_c) to_hit_c = 1'b1;
            ST_NET:   if (rdone_s) state_d = ST_SOC; else if (timeout_c) to_hit_c = 1'b1;
            ST_SOC:   if (soc_cnt_q == SOC_W'(SOC_SETTLE - 1)) state_d = ST_RUN;
            ST_RUN:   if (!calib_s || !rdone_s) state_d = ST_HOLD;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_HOLD;
        endcase

        if (to_hit_c) begin
`ifdef RST_SEQ_RETRY_EN
            if (retry_q == RTY_W'(MAX_RETRIES)) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_HOLD;
                retry_d = retry_q + RTY_W'(1);
            end
`else
            state_d = ST_FAULT;
`endif
        end

        // Software restart wins over any timeout or ready event this cycle.
        if (bus.sw_rst_req_i) state_d = ST_HOLD;
        entry_c = (state_d != state_q);

        if (entry_c || bus.sw_rst_req_i) begin
            hold_cnt_d = '0;
            to_cnt_d   = '0;
            soc_cnt_d  = '0;
        end else begin
            if (state_q == ST_HOLD && hold_cnt_q != HOLD_W'(HOLD_CYCLES))
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if ((state_q == ST_DDR || state_q == ST_NET) && to_cnt_q != TO_W'(TIMEOUT_CYCLES))
                to_cnt_d = to_cnt_q + TO_W'(1);
            if (state_q == ST_SOC && soc_cnt_q != SOC_W'(SOC_SETTLE))
                soc_cnt_d = soc_cnt_q + SOC_W'(1);
        end

`ifdef RST_SEQ_RETRY_EN
        if (bus.sw_rst_req_i || (entry_c && state_d == ST_RUN)) retry_d = '0;
`endif
    end

    // State, counters and Moore output decodes of the next state share one edge.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            soc_cnt_q   <= '0;
            ddr_rst_q   <= 1'b1;
            net_rst_q   <= 1'b1;
            soc_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            soc_cnt_q   <= soc_cnt_d;
            ddr_rst_q   <= (state_d == ST_HOLD) || (state_d == ST_FAULT);
            net_rst_q   <= (state_d == ST_HOLD) || (state_d == ST_DDR) || (state_d == ST_FAULT);
            soc_rst_n_q <= (state_d == ST_SOC) || (state_d == ST_RUN);
            done_q      <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

`ifdef RST_SEQ_RETRY_EN
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) retry_q <= '0;
        else           retry_q <= retry_d;
    end
`endif

    assign bus.ddr_rst_o   = ddr_rst_q;
    assign bus.net_rst_o   = net_rst_q;
    assign bus.soc_rst_n_o = soc_rst_n_q;
    assign bus.done_o      = done_q;
    assign bus.fault_o     = fault_q;
    assign bus.state_o     = 3'(state_q);
endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: vector table for the nominal bring-up,
// hand-written sequences for RUN drops, timeouts/retries and software restarts.
module tb_rst_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rst_sequencer_if bus();

    rst_sequencer #(
        .HOLD_CYCLES    (16),
        .TIMEOUT_CYCLES (64),
        .SOC_SETTLE     (4),
        .MAX_RETRIES    (2)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (bus)
    );

    typedef struct {
        int   cyc;
        logic calib;
        logic rdone;
        int   st;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] exp;
        int         tag;
    } sb_t;

    vec_t vecs[11];
    sb_t  sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   next_tag = 0;
    int   fcyc;

    // Expected {fault, done, soc_rst_n, net_rst, ddr_rst, state} for each state.
    function automatic logic [7:0] exp_of(input int st);
        case (st)
            0:       return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
            1:       return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
            2:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
            3:       return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
            4:       return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
            default: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5};
        endcase
    endfunction

    function automatic logic [7:0] actual();
        return {bus.fault_o, bus.done_o, bus.soc_rst_n_o, bus.net_rst_o, bus.ddr_rst_o, bus.state_o};
    endfunction

    task automatic push(input int c, input int st);
        sb_t e;
        e.cyc = c;
        e.exp = exp_of(st);
        e.tag = next_tag;
        next_tag++;
        sbq.push_back(e);
    endtask

    task automatic check_q();
        sb_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL chk%0d missed: expected at cycle %0d, now %0d", e.tag, e.cyc, cyc);
            end else if (actual() !== e.exp) begin
                n_fail++;
                $display("FAIL chk%0d cycle %0d {fault,done,soc_n,net,ddr,state} got %b want %b",
                         e.tag, cyc, actual(), e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_q();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,  1'b0, 1'b0, 0};
        vecs[1]  = '{15, 1'b0, 1'b0, 0};
        vecs[2]  = '{16, 1'b0, 1'b0, 1};
        vecs[3]  = '{30, 1'b1, 1'b0, 1};
        vecs[4]  = '{32, 1'b1, 1'b0, 1};
        vecs[5]  = '{33, 1'b1, 1'b0, 2};
        vecs[6]  = '{50, 1'b1, 1'b1, 2};
        vecs[7]  = '{52, 1'b1, 1'b1, 2};
        vecs[8]  = '{53, 1'b1, 1'b1, 3};
        vecs[9]  = '{56, 1'b1, 1'b1, 3};
        vecs[10] = '{57, 1'b1, 1'b1, 4};

        rst = 1'b1;
        bus.sw_rst_req_i    = 1'b0;
        bus.ddr_calib_i     = 1'b0;
        bus.net_resetdone_i = 1'b0;
        tick();
        tick();
        push(cyc, 0);
        check_q();
        rst = 1'b0;
        cyc = 0;

        // Nominal bring-up from the vector table.
        foreach (vecs[i]) begin
            run_until(vecs[i].cyc);
            bus.ddr_calib_i     = vecs[i].calib;
            bus.net_resetdone_i = vecs[i].rdone;
            push(vecs[i].cyc, vecs[i].st);
            check_q();
        end

        // Sub-cycle glitch on resetdone is never sampled: stay in RUN.
        run_until(60);
        #1 bus.net_resetdone_i = 1'b0;
        #2 bus.net_resetdone_i = 1'b1;
        push(62, 4);
        push(66, 4);
        run_until(66);

        // A 4-cycle drop returns to HOLD, then a fast re-sequence with ready inputs already high.
        run_until(70);
        bus.net_resetdone_i = 1'b0;
        push(72, 4);
        push(73, 0);
        run_until(74);
        bus.net_resetdone_i = 1'b1;
        push(88, 0);
        push(89, 1);
        push(90, 2);
        push(91, 3);
        push(94, 3);
        push(95, 4);
        run_until(95);

        // Reset while in RUN, then calib high from reset and resetdone never arrives.
        rst = 1'b1;
        bus.ddr_calib_i     = 1'b1;
        bus.net_resetdone_i = 1'b0;
        tick();
        tick();
        push(cyc, 0);
        check_q();
        rst = 1'b0;
        cyc = 0;
        push(15, 0);
        push(16, 1);
        push(17, 2);
        push(80, 2);
`ifdef RST_SEQ_RETRY_EN
        push(81, 0);
        push(97, 1);
        push(98, 2);
        push(161, 2);
        push(162, 0);
        push(179, 2);
        push(242, 2);
        push(243, 5);
        fcyc = 243;
`else
        push(81, 5);
        push(90, 5);
        fcyc = 90;
`endif
        run_until(fcyc);

        // Software restart out of FAULT clears fault and restarts the HOLD count.
        bus.ddr_calib_i  = 1'b0;
        bus.sw_rst_req_i = 1'b1;
        push(fcyc + 1, 0);
        tick();
        bus.sw_rst_req_i = 1'b0;
        push(fcyc + 16, 0);
        push(fcyc + 17, 1);
        run_until(fcyc + 20);
        bus.ddr_calib_i = 1'b1;

        // Restart in the same cycle the synchronized calib is first seen high.
        push(fcyc + 22, 1);
        run_until(fcyc + 22);
        bus.sw_rst_req_i = 1'b1;
        push(fcyc + 23, 0);
        tick();
        bus.sw_rst_req_i = 1'b0;
        push(fcyc + 38, 0);
        push(fcyc + 39, 1);
        push(fcyc + 40, 2);
        run_until(fcyc + 40);

        while (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL chk%0d never reached (cycle %0d)", sbq[0].tag, sbq[0].cyc);
            void'(sbq.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024: number of cycles all downstream resets stay asserted after sequence start.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2**20: maximum number of cycles to wait for each ready input.
REQ-003 SHALL have parameter SOC_SETTLE, default 16: number of cycles between SoC reset release and done_o.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of consecutive timeouts tolerated before fault (used only with RST_SEQ_RETRY_EN).
REQ-005 SHALL have port sys_clk_i, input, 1 bit: the single clock; all logic in the block is clocked by it.
REQ-006 SHALL have port sys_rst_i, input, 1 bit: reset, synchronous to sys_clk_i and active-high.
REQ-007 SHALL have port sw_rst_req_i, input, 1 bit: synchronous single-cycle request to restart the sequence.
REQ-008 SHALL have port ddr_calib_i, input, 1 bit: DDR3 init_calib_complete; asynchronous to sys_clk_i.
REQ-009 SHALL have port net_resetdone_i, input, 1 bit: transceiver resetdone; asynchronous to sys_clk_i.
REQ-010 SHALL have port ddr_rst_o, output, 1 bit: DDR3 controller reset, active-high.
REQ-011 SHALL have port net_rst_o, output, 1 bit: network transceiver reset, active-high.
REQ-012 SHALL have port soc_rst_n_o, output, 1 bit: SoC reset, active-low.
REQ-013 SHALL have port done_o, output, 1 bit: high while the system is fully out of reset.
REQ-014 SHALL have port fault_o, output, 1 bit: sticky indication that the sequence failed.
REQ-015 SHALL have port state_o, output, 3 bits: current state for debug (HOLD=0, DDR=1, NET=2, SOC=3, RUN=4, FAULT=5).

Function
REQ-016 SHALL pass ddr_calib_i and net_resetdone_i through two-flop synchronizers; the state machine SHALL use only the synchronized values (2-cycle latency).
REQ-017 SHALL implement states HOLD, DDR, NET, SOC, RUN and FAULT.
REQ-018 SHALL register all outputs as Moore decodes updated on the same edge as the state register, so no output glitches.
REQ-019 HOLD SHALL assert ddr_rst_o=1 and net_rst_o=1, drive soc_rst_n_o=0, and go to DDR after exactly HOLD_CYCLES cycles in HOLD.
REQ-020 DDR SHALL drive ddr_rst_o=0 and go to NET on the first cycle the synchronized calib input is high.
REQ-021 NET SHALL drive net_rst_o=0 and go to SOC on the first cycle the synchronized resetdone input is high.
REQ-022 SOC SHALL drive soc_rst_n_o=1 and go to RUN after exactly SOC_SETTLE cycles.
REQ-023 RUN SHALL drive done_o=1 and go to HOLD if either synchronized ready input drops; it SHALL clear the retry counter on entry.
REQ-024 DDR and NET SHALL each restart the shared timeout counter on entry; reaching TIMEOUT_CYCLES SHALL count as a timeout.
REQ-025 FAULT SHALL drive fault_o=1 and done_o=0, hold ddr_rst_o=1 and net_rst_o=1, and drive soc_rst_n_o=0.
REQ-026 FAULT SHALL be left only by sys_rst_i or sw_rst_req_i.
REQ-027 sw_rst_req_i in any state SHALL force HOLD on the next edge with all counters cleared; it SHALL take priority over a timeout or ready event in the same cycle.
REQ-028 Each counter SHALL be sized $clog2(param+1) bits and SHALL saturate, never wrap.
REQ-029 A ready input that is already high on entry to its wait state SHALL cause exit after one cycle in that state.

Reset
REQ-030 sys_rst_i SHALL synchronously force state HOLD, clear all counters, the retry counter and the synchronizers, and set ddr_rst_o=1, net_rst_o=1, soc_rst_n_o=0, done_o=0, fault_o=0 and state_o=0.
REQ-031 Reset asserted mid-sequence SHALL restart from HOLD; the HOLD count SHALL begin on the first cycle after sys_rst_i deasserts.

Configuration
REQ-032 With the macro RST_SEQ_RETRY_EN defined, a timeout SHALL go to HOLD and increment the retry counter, and the timeout that would make the count exceed MAX_RETRIES SHALL go to FAULT instead.
REQ-033 Without RST_SEQ_RETRY_EN defined, any timeout SHALL go directly to FAULT and no retry counter SHALL be synthesized.

Verification
REQ-034 Bench SHALL drive HOLD_CYCLES=16 and SOC_SETTLE=4, release reset at cycle 0, raise calib at cycle 30 and resetdone at cycle 50 -> require ddr_rst_o to fall at cycle 16, net_rst_o to fall at 32 (±1), soc_rst_n_o to rise at 52 (±1), and done_o to rise 4 cycles after soc_rst_n_o.
REQ-035 Bench SHALL hold calib high from reset with TIMEOUT_CYCLES=64 and never raise resetdone, without the macro -> require fault_o=1 and state_o=5 when 64 cycles in NET have elapsed, with resets asserted.
REQ-036 Bench SHALL repeat REQ-035 with RST_SEQ_RETRY_EN defined and MAX_RETRIES=2 -> require two returns to state_o=0, then FAULT on the third timeout.
REQ-037 Bench SHALL drop resetdone for 1 cycle while in RUN -> require no reaction (pulse filtered only if not sampled); a 4-cycle drop -> require HOLD, done_o=0, all resets reasserted.
REQ-038 Bench SHALL pulse sw_rst_req_i in FAULT and again mid-DDR in the same cycle calib rises -> require HOLD entered both times, fault_o cleared, and the HOLD count restarted.
